// File: rtl/linx_axil_pkg.sv
// Shared types for linx_axil_master: FSM state encoding and AXI RESP codes.
package linx_axil_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      RSP
   } state_e;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/linx_axil_master.sv
// Single-outstanding AXI4-Lite master behind a valid/ready request/response port.
// Optional watchdog enabled by defining LINX_AXIL_TIMEOUT_EN.
module linx_axil_master
   import linx_axil_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   input  logic [3:0]        req_wstrb,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] m_axi_awaddr,
   output logic              m_axi_awvalid,
   input  logic              m_axi_awready,
   output logic [31:0]       m_axi_wdata,
   output logic [3:0]        m_axi_wstrb,
   output logic              m_axi_wvalid,
   input  logic              m_axi_wready,
   input  logic [1:0]        m_axi_bresp,
   input  logic              m_axi_bvalid,
   output logic              m_axi_bready,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,
   input  logic [31:0]       m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready,
   output logic              busy
);

   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("linx_axil_master: TIMEOUT_CYCLES must be at least 2");
   end

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [1:0]        resp_q, resp_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q, w_done_d;
   logic              accept;

`ifdef LINX_AXIL_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
`endif

   assign accept = (state_q == IDLE) && req_valid;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      rdata_d   = rdata_q;
      resp_d    = resp_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
`ifdef LINX_AXIL_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d    = req_addr;
               wdata_d   = req_wdata;
               wstrb_d   = req_wstrb;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               state_d   = req_write ? WADDR : RADDR;
            end
         end
         WADDR: begin
            // AW and W complete independently; a ready seen after its own handshake is ignored
            aw_done_d = aw_done_q | m_axi_awready;
            w_done_d  = w_done_q | m_axi_wready;
            if (aw_done_d && w_done_d) state_d = WRESP;
         end
         WRESP: begin
            if (m_axi_bvalid) begin
               resp_d  = m_axi_bresp;
               rdata_d = '0;
               state_d = RSP;
            end
         end
         RADDR: begin
            if (m_axi_arready) state_d = RDATA;
         end
         RDATA: begin
            if (m_axi_rvalid) begin
               rdata_d = m_axi_rdata;
               resp_d  = m_axi_rresp;
               state_d = RSP;
            end
         end
         RSP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef LINX_AXIL_TIMEOUT_EN
      // The accept edge counts as the first elapsed cycle, so RSP appears TIMEOUT_CYCLES after accept
      if (accept) begin
         cnt_d     = '0;
         timeout_d = 1'b0;
      end else if (state_q != IDLE && state_q != RSP) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = RSP;
            resp_d    = RESP_SLVERR;
            rdata_d   = '0;
            timeout_d = 1'b1;
         end
      end
`endif
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         resp_q    <= RESP_OKAY;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
`ifdef LINX_AXIL_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
`ifdef LINX_AXIL_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   assign req_ready     = (state_q == IDLE);
   assign busy          = (state_q != IDLE);
   assign rsp_valid     = (state_q == RSP);
   assign rsp_rdata     = rdata_q;
   assign rsp_resp      = resp_q;
`ifdef LINX_AXIL_TIMEOUT_EN
   assign rsp_timeout   = timeout_q;
`else
   assign rsp_timeout   = 1'b0;
`endif

   assign m_axi_awaddr  = addr_q;
   assign m_axi_awvalid = (state_q == WADDR) && !aw_done_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_wvalid  = (state_q == WADDR) && !w_done_q;
   assign m_axi_bready  = (state_q == WRESP);
   assign m_axi_araddr  = addr_q;
   assign m_axi_arvalid = (state_q == RADDR);
   assign m_axi_rready  = (state_q == RDATA);

endmodule

// File: doc/linx_axil_master.md
LINX_AXIL_MASTER -- requirements
Module: linx_axil_master

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, AXI address width.
REQ-002 SHALL have parameter: TIMEOUT_CYCLES, 1024, watchdog limit in cycles, used only when LINX_AXIL_TIMEOUT_EN is defined.
REQ-003 SHALL have port: aclk  in  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port: aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: req_valid in 1 / req_ready out 1  command handshake.
REQ-006 SHALL have ports: req_write in 1 (1=write), req_addr in ADDR_W, req_wdata in 32, req_wstrb in 4  command payload.
REQ-007 SHALL have ports: rsp_valid out 1 / rsp_ready in 1  completion handshake.
REQ-008 SHALL have ports: rsp_rdata out 32, rsp_resp out 2 (AXI RESP encoding), rsp_timeout out 1  completion payload.
REQ-009 SHALL have ports: m_axi_awaddr out ADDR_W, m_axi_awvalid out 1, m_axi_awready in 1  AW channel.
REQ-010 SHALL have ports: m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wvalid out 1, m_axi_wready in 1  W channel.
REQ-011 SHALL have ports: m_axi_bresp in 2, m_axi_bvalid in 1, m_axi_bready out 1  B channel.
REQ-012 SHALL have ports: m_axi_araddr out ADDR_W, m_axi_arvalid out 1, m_axi_arready in 1  AR channel.
REQ-013 SHALL have ports: m_axi_rdata in 32, m_axi_rresp in 2, m_axi_rvalid in 1, m_axi_rready out 1  R channel.
REQ-014 SHALL have port: busy  out  1  high when state is not IDLE.

Function
REQ-015 SHALL allow one outstanding transaction; req_ready = (state==IDLE).
REQ-016 SHALL implement states IDLE, WADDR, WRESP, RADDR, RDATA, RSP.
REQ-017 SHALL register the payload when req_valid&&req_ready, then go to WADDR if req_write, else RADDR.
REQ-018 In WADDR, SHALL assert awvalid and wvalid together, starting the cycle after accept; each drops on its own handshake (aw_done/w_done flags); either order or the same cycle is legal; both done -> WRESP.
REQ-019 In WRESP, SHALL hold bready=1; on bvalid, capture bresp, set rdata=0, go to RSP.
REQ-020 In RADDR, SHALL hold arvalid until arready, then go to RDATA; in RDATA, hold rready=1; on rvalid, capture rdata/rresp, go to RSP.
REQ-021 In RSP, SHALL hold rsp_valid and stable payload until rsp_ready, then go to IDLE; the next accept may occur the following cycle.
REQ-022 SHALL never withdraw an AXI valid before its handshake and SHALL keep addr/data/strb stable while valid is high.
REQ-023 SHALL assert bready only in WRESP and rready only in RDATA.
REQ-024 SHALL pass req_addr unaltered and issue wstrb=0 as-is, with no alignment check.
REQ-025 Minimum latency: accept at cycle N, AW/W handshake at N+1, B at N+2, rsp_valid at N+3.

Reset
REQ-026 While aresetn is low, SHALL hold state IDLE, all AXI valids/readies 0, rsp_valid 0, rsp payload 0, busy 0, req_ready 1.
REQ-027 Reset mid-transaction SHALL abandon it immediately with no response generated.

Configuration
REQ-028 With LINX_AXIL_TIMEOUT_EN defined, a counter SHALL clear on accept and increment in every state except IDLE/RSP; on reaching TIMEOUT_CYCLES the block SHALL drop all AXI valids/readies and enter RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0.
REQ-029 After a timeout, stale B/R beats are not drained; behaviour of later transactions is undefined until reset.
REQ-030 Without LINX_AXIL_TIMEOUT_EN, there SHALL be no counter, rsp_timeout SHALL be tied 0, and the block waits indefinitely.

Structure
REQ-031 Package linx_axil_pkg SHALL hold the state enum and RESP constants (OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11).
REQ-032 Single module; no sub-module; the watchdog is inline.

Verification
REQ-033 Write 0xDEADBEEF to 0x10, strb 0xF, slave always ready, bresp OKAY -> AW/W handshake at N+1, rsp_valid at N+3, rsp_resp=00.
REQ-034 wready at N+1, awready delayed 5 cycles -> wvalid high exactly 1 cycle, awvalid held 6 cycles with stable addr, exactly one response.
REQ-035 Read 0x20, arready delay 3, rvalid delay 2, rdata 0x12345678 -> rsp_rdata=0x12345678, rsp_resp=00.
REQ-036 rsp_ready low for 4 cycles -> rsp_valid/payload stable, req_ready 0, no AXI valids; bresp 2'b11 -> rsp_resp=2'b11.
REQ-037 Timeout build, TIMEOUT_CYCLES=16, arready never asserted -> rsp_valid with rsp_resp=10, rsp_timeout=1, 16 cycles after accept.
REQ-038 aresetn low during RDATA -> rready/arvalid 0 immediately, no rsp_valid, req_ready=1 after release.
